// File: rtl/md_issue.sv
// Issue controller between the E stage and the HI/LO multiply/divide unit.
// Presents one registered command cycle, tracks the unit's busy window and stalls MD requests meanwhile.
module md_issue (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    input  logic [3:0]  req_op_i,
    input  logic [31:0] req_a_i,
    input  logic [31:0] req_b_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic [3:0]  md_op_o,
    output logic        md_start_o,
    output logic [31:0] a_o,
    output logic [31:0] b_o,
    input  logic        md_busy_i,
    input  logic [31:0] md_out_i,
    output logic        rd_valid_o,
    output logic [31:0] rd_data_o,
    output logic        done_o,
    output logic        div_zero_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_e;

    state_e      state_q;
    logic [3:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [3:0]  md_op_q;
    logic        md_start_q;
    logic [31:0] rd_data_q;
    logic        rd_valid_q;
    logic        done_q;
    logic        div_zero_q;

    logic        occupied_s;
    logic        accept_s;
    logic [3:0]  md_op_d;
    logic        md_start_d;

    function automatic logic is_mul(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd6);
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == 4'd14) || (op == 4'd15);
    endfunction

    function automatic logic is_rd(input logic [3:0] op);
        return (op == 4'd9) || (op == 4'd10);
    endfunction

    // Command decode of the incoming request; no-op codes reach the unit as 0.
    always_comb begin
        md_start_d = is_mul(req_op_i) || is_div(req_op_i);
        if (md_start_d || ((req_op_i >= 4'd7) && (req_op_i <= 4'd10))) begin
            md_op_d = req_op_i;
        end else begin
            md_op_d = 4'd0;
        end
    end

    // A stale busy after reset is ignored because occupancy requires a non-idle state.
    assign occupied_s = (state_q == S_ISSUE) || ((state_q == S_WAIT) && md_busy_i);
    assign stall_o    = req_valid_i && occupied_s && !flush_i;
    assign accept_s   = req_valid_i && !occupied_s && !flush_i;

    // Issue FSM with all unit-facing and pipeline-facing outputs registered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            op_q       <= 4'd0;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            md_op_q    <= 4'd0;
            md_start_q <= 1'b0;
            rd_data_q  <= 32'd0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            md_op_q    <= 4'd0;
            md_start_q <= 1'b0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            if (accept_s) begin
                op_q       <= req_op_i;
                a_q        <= req_a_i;
                b_q        <= req_b_i;
                md_op_q    <= md_op_d;
                md_start_q <= md_start_d;
            end
            case (state_q)
                S_IDLE: begin
                    state_q <= accept_s ? S_ISSUE : S_IDLE;
                end
                S_ISSUE: begin
                    if (is_mul(op_q) || (is_div(op_q) && (b_q != 32'd0))) begin
                        state_q <= S_WAIT;
                    end else begin
                        state_q    <= S_IDLE;
                        done_q     <= 1'b1;
                        div_zero_q <= is_div(op_q);
                        if (is_rd(op_q)) begin
                            rd_data_q  <= md_out_i;
                            rd_valid_q <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (!md_busy_i) begin
                        done_q  <= 1'b1;
                        state_q <= accept_s ? S_ISSUE : S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign md_op_o    = md_op_q;
    assign md_start_o = md_start_q;
    assign a_o        = a_q;
    assign b_o        = b_q;
    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign done_o     = done_q;
    assign div_zero_o = div_zero_q;

endmodule

// File: tb/tb_md_issue.sv
// Bench for md_issue: behavioural HI/LO unit, cycle-scheduled expectation model and directed scenarios.
module tb_md_issue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [3:0]  req_op = 4'd0;
    logic [31:0] req_a = 32'd0;
    logic [31:0] req_b = 32'd0;
    logic        flush = 1'b0;
    logic        stall_o, md_start_o, rd_valid_o, done_o, div_zero_o;
    logic [3:0]  md_op_o;
    logic [31:0] a_o, b_o, rd_data_o;
    logic        md_busy;
    logic [31:0] md_out;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    md_issue dut (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_op_i(req_op),
        .req_a_i(req_a), .req_b_i(req_b), .flush_i(flush), .stall_o(stall_o),
        .md_op_o(md_op_o), .md_start_o(md_start_o), .a_o(a_o), .b_o(b_o),
        .md_busy_i(md_busy), .md_out_i(md_out), .rd_valid_o(rd_valid_o),
        .rd_data_o(rd_data_o), .done_o(done_o), .div_zero_o(div_zero_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] md_result(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [63:0] hl);
        logic signed [63:0] sa, sb, sp;
        logic        [63:0] up;
        logic signed [31:0] qa, qb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        sp = sa * sb;
        up = {32'd0, a} * {32'd0, b};
        qa = a;
        qb = b;
        case (op)
            4'd1:    return sp;
            4'd2:    return up;
            4'd3:    return hl + sp;
            4'd4:    return hl + up;
            4'd5:    return hl - sp;
            4'd6:    return hl - up;
            4'd14:   return {32'(qa % qb), 32'(qa / qb)};
            4'd15:   return {a % b, a / b};
            default: return hl;
        endcase
    endfunction

    // Behavioural MD unit: mult family busy 5 cycles, divide busy 10, divide by zero ignored.
    logic [63:0] hl;
    int          bcnt;
    logic        busy_seen = 1'b0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hl   <= 64'd0;
            bcnt <= 0;
        end else begin
            if (md_start_o && ((md_op_o >= 4'd1 && md_op_o <= 4'd6) ||
                               ((md_op_o == 4'd14 || md_op_o == 4'd15) && b_o != 32'd0))) begin
                hl   <= md_result(md_op_o, a_o, b_o, hl);
                bcnt <= (md_op_o <= 4'd6) ? 5 : 10;
            end else if (bcnt != 0) begin
                bcnt <= bcnt - 1;
            end
            if (md_op_o == 4'd7) hl[63:32] <= a_o;
            if (md_op_o == 4'd8) hl[31:0]  <= a_o;
        end
    end
    assign md_busy = (bcnt != 0);
    assign md_out  = (md_op_o == 4'd10) ? hl[31:0] : hl[63:32];
    always @(posedge clk) if (md_busy) busy_seen <= 1'b1;

    // Expectation model: each accepted request schedules its outputs at absolute future cycles.
    logic        e_issue [64], e_start [64], e_done [64], e_dz [64], e_rdv [64];
    logic [3:0]  e_op [64];
    logic [31:0] e_a [64], e_b [64], e_rdval [64];
    logic [31:0] arch_hi = 32'd0, arch_lo = 32'd0, exp_rd = 32'd0;
    int          occ_until = -1;

    always @(negedge clk) begin
        int s;
        logic exp_stall, mul, dv, lng;
        int n;
        s = cyc % 64;
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) begin
                e_issue[i] = 1'b0; e_start[i] = 1'b0; e_done[i] = 1'b0;
                e_dz[i] = 1'b0; e_rdv[i] = 1'b0; e_op[i] = 4'd0;
            end
            arch_hi = 32'd0; arch_lo = 32'd0; exp_rd = 32'd0; occ_until = -1;
            chk("rst_stall", stall_o, 1'b0);
            chk("rst_mdop", md_op_o, 4'd0);
            chk("rst_start", md_start_o, 1'b0);
            chk("rst_a", a_o, 32'd0);
            chk("rst_b", b_o, 32'd0);
            chk("rst_rddata", rd_data_o, 32'd0);
            chk("rst_rdvalid", rd_valid_o, 1'b0);
            chk("rst_done", done_o, 1'b0);
            chk("rst_divzero", div_zero_o, 1'b0);
        end else begin
            exp_stall = req_valid && (cyc <= occ_until) && !flush;
            if (e_rdv[s]) exp_rd = e_rdval[s];
            chk("stall", stall_o, exp_stall);
            chk("mdop", md_op_o, e_issue[s] ? e_op[s] : 4'd0);
            chk("mdstart", md_start_o, e_issue[s] && e_start[s]);
            chk("done", done_o, e_done[s]);
            chk("divzero", div_zero_o, e_dz[s]);
            chk("rdvalid", rd_valid_o, e_rdv[s]);
            chk("rddata", rd_data_o, exp_rd);
            if (e_issue[s]) begin
                chk("opA", a_o, e_a[s]);
                chk("opB", b_o, e_b[s]);
            end
            e_issue[s] = 1'b0; e_done[s] = 1'b0; e_dz[s] = 1'b0; e_rdv[s] = 1'b0;
            if (req_valid && (cyc > occ_until) && !flush) begin
                mul = (req_op inside {[4'd1:4'd6]});
                dv  = (req_op inside {4'd14, 4'd15});
                lng = mul || (dv && req_b != 32'd0);
                n   = mul ? 5 : 10;
                e_issue[(cyc+1)%64] = 1'b1;
                e_op[(cyc+1)%64]    = (req_op inside {[4'd1:4'd10], 4'd14, 4'd15}) ? req_op : 4'd0;
                e_start[(cyc+1)%64] = mul || dv;
                e_a[(cyc+1)%64]     = req_a;
                e_b[(cyc+1)%64]     = req_b;
                occ_until = lng ? cyc + 1 + n : cyc + 1;
                e_done[(lng ? cyc + 3 + n : cyc + 2) % 64] = 1'b1;
                if (dv && !lng) e_dz[(cyc+2)%64] = 1'b1;
                if (req_op == 4'd9 || req_op == 4'd10) begin
                    e_rdv[(cyc+2)%64]   = 1'b1;
                    e_rdval[(cyc+2)%64] = (req_op == 4'd9) ? arch_hi : arch_lo;
                end
                if (lng) {arch_hi, arch_lo} = md_result(req_op, req_a, req_b, {arch_hi, arch_lo});
                if (req_op == 4'd7) arch_hi = req_a;
                if (req_op == 4'd8) arch_lo = req_a;
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int nstall);
        logic acc;
        acc = 1'b0;
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; flush = 1'b0; nstall = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            acc = !stall_o;
            @(posedge clk); #1;
            if (acc) break;
            nstall++;
        end
        chk("accept_in_time", acc, 1'b1);
    endtask

    task automatic idle();
        req_valid = 1'b0; req_op = 4'd0; flush = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!done_o && n < 30);
    endtask

    task automatic read_check(input string name, input logic [31:0] exp);
        idle();
        @(posedge clk); #1;
        chk({name, "_valid"}, rd_valid_o, 1'b1);
        chk(name, rd_data_o, exp);
        @(posedge clk); #1;
        chk({name, "_pulse"}, rd_valid_o, 1'b0);
    endtask

    task automatic mult_scenario(input string tag);
        int ns, nd;
        issue(4'd1, 32'd3, 32'hFFFF_FFFC, ns);
        chk({tag, "_mdop"}, md_op_o, 4'd1);
        chk({tag, "_start"}, md_start_o, 1'b1);
        chk({tag, "_a"}, a_o, 32'd3);
        idle();
        wait_done(nd);
        chk({tag, "_done_lat"}, nd, 7);
        issue(4'd10, 32'd0, 32'd0, ns);
        read_check({tag, "_mflo"}, 32'hFFFF_FFF4);
        issue(4'd9, 32'd0, 32'd0, ns);
        read_check({tag, "_mfhi"}, 32'hFFFF_FFFF);
    endtask

    initial begin
        int ns, nd;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        mult_scenario("mult");

        issue(4'd14, 32'd7, 32'd2, ns);
        issue(4'd9, 32'd0, 32'd0, ns);
        chk("div_stall_cycles", ns, 11);
        read_check("div_mfhi", 32'd1);
        issue(4'd10, 32'd0, 32'd0, ns);
        read_check("div_mflo", 32'd3);

        busy_seen = 1'b0;
        issue(4'd15, 32'd5, 32'd0, ns);
        idle();
        @(posedge clk); #1;
        chk("dz_pulse", div_zero_o, 1'b1);
        chk("dz_done", done_o, 1'b1);
        issue(4'd9, 32'd0, 32'd0, ns);
        chk("dz_next_accept", ns, 0);
        chk("dz_no_busy", busy_seen, 1'b0);
        read_check("dz_mfhi", 32'd1);

        issue(4'd7, 32'h1234, 32'd0, ns);
        chk("mthi_mdop", md_op_o, 4'd7);
        issue(4'd9, 32'd0, 32'd0, ns);
        chk("mthi_gap", ns, 1);
        read_check("mthi_mfhi", 32'h1234);

        req_valid = 1'b1; req_op = 4'd1; req_a = 32'd5; req_b = 32'd5; flush = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("flush_idle_stall", stall_o, 1'b0);
            @(posedge clk); #1;
            chk("flush_idle_mdop", md_op_o, 4'd0);
        end
        idle();

        issue(4'd1, 32'd6, 32'd7, ns);
        req_valid = 1'b1; req_op = 4'd9; flush = 1'b1;
        wait_done(nd);
        chk("flush_wait_done_lat", nd, 7);
        idle();
        @(posedge clk); #1;

        issue(4'd14, 32'd100, 32'd3, ns);
        idle();
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_a", a_o, 32'd0);
        chk("async_rst_b", b_o, 32'd0);
        chk("async_rst_rddata", rd_data_o, 32'd0);
        chk("async_rst_mdop", md_op_o, 4'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        mult_scenario("post_rst");

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

endmodule
